// File: rtl/rr_arbiter_n_if.sv
// Handshake bundle between requesting input ports, the arbiter and the downstream link.
//   req      : per-port request (port i has a flit)
//   tail     : per-port tail-flit flag, sampled with the transfer
//   dcts     : downstream clear-to-send
//   grant    : one-hot transfer strobe to the granted input port
//   xbar_sel : one-hot crossbar select
//   rts      : request-to-send to downstream
//   busy     : arbiter not idle
// Modports: master = requester/downstream side, slave = arbiter.
interface rr_arbiter_n_if #(
    parameter int unsigned NUM_PORTS = 5
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] tail;
    logic                 dcts;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] xbar_sel;
    logic                 rts;
    logic                 busy;

    modport master (
        output req, tail, dcts,
        input  grant, xbar_sel, rts, busy
    );

    modport slave (
        input  req, tail, dcts,
        output grant, xbar_sel, rts, busy
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for NUM_PORTS input ports onto one downstream link.
// Each grant is a SEND/GAP pair, so peak throughput is one transfer per two cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rr_arbiter_n_if.slave (req, tail, dcts in; grant, xbar_sel, rts, busy out)
// Build option: define ARB_PACKET_LOCK_EN for wormhole packet locking (the
// granted port keeps the link until it transfers a tail flit, and the next
// packet search starts after the previous owner).
module rr_arbiter_n #(
    parameter int unsigned NUM_PORTS = 5
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] NP_SUM = SUM_W'(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_cur, w_cur_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic                 r_lock, w_lock_nxt;
    logic [IDX_W-1:0]     w_cur_inc;
    logic [IDX_W-1:0]     w_start;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_found;
    logic [SUM_W-1:0]     w_idx;
    logic [NUM_PORTS-1:0] w_cur_oh;
    logic                 w_send;

    // Modulo increment; never yields an index >= NUM_PORTS.
    assign w_cur_inc = (r_cur == LAST_IDX) ? '0 : r_cur + IDX_W'(1);
    assign w_cur_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_cur;
    assign w_send    = (r_state == S_SEND);

    // Outputs decoded from registers; grant additionally qualified by dcts.
    assign bus.rts      = w_send;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.xbar_sel = w_send ? w_cur_oh : '0;
    assign bus.grant    = (w_send && bus.dcts) ? w_cur_oh : '0;

`ifndef ARB_PACKET_LOCK_EN
    logic w_unused_tail;
    assign w_unused_tail = ^bus.tail;
`endif

    // Search origin: ptr from IDLE; in GAP, the last owner (or the one after it when locking).
    always_comb begin
        w_start = r_ptr;
        if (r_state == S_GAP) begin
`ifdef ARB_PACKET_LOCK_EN
            w_start = w_cur_inc;
`else
            w_start = r_cur;
`endif
        end
    end

    // First set request at or after w_start, wrapping modulo NUM_PORTS.
    always_comb begin
        w_found = 1'b0;
        w_pick  = w_start;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = SUM_W'(w_start) + SUM_W'(k);
            if (w_idx >= NP_SUM) begin
                w_idx = w_idx - NP_SUM;
            end
            if (!w_found && bus.req[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IDX_W-1:0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_cur_nxt   = w_pick;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.dcts) begin
                    w_state_nxt = S_GAP;
                    w_ptr_nxt   = w_cur_inc;
`ifdef ARB_PACKET_LOCK_EN
                    w_lock_nxt  = ~bus.tail[r_cur];
`else
                    w_lock_nxt  = 1'b0;
`endif
                end
            end
            S_GAP: begin
                // r_lock is constant 0 unless packet locking is built in.
                if (r_lock) begin
                    if (bus.req[r_cur]) begin
                        w_state_nxt = S_SEND;
                    end
                end else if (w_found) begin
                    w_cur_nxt   = w_pick;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_ptr   <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (NUM_PORTS = 5). The driver pushes the
// expected outputs for each driven cycle; a monitor pops them at the falling edge.
module tb_rr_arbiter_n;
    localparam int unsigned NP = 5;

    typedef struct packed {
        logic          rts;
        logic [NP-1:0] gnt;
        logic [NP-1:0] xs;
        logic          busy;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    exp_t m_exp;
    int   n_vec;
    int   n_err;

    rr_arbiter_n_if #(.NUM_PORTS(NP)) bus ();

    rr_arbiter_n #(.NUM_PORTS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic step(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] tl,
                        input logic d, input logic e_rts, input logic [NP-1:0] e_gnt,
                        input logic [NP-1:0] e_xs, input logic e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        bus.req  = rq;
        bus.tail = tl;
        bus.dcts = d;
        e.rts  = e_rts;
        e.gnt  = e_gnt;
        e.xs   = e_xs;
        e.busy = e_busy;
        sb_q.push_back(e);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.tail = '0;
        bus.dcts = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (sb_q.size() != 0) begin
                    m_exp = sb_q.pop_front();
                    n_vec++;
                    if (bus.rts !== m_exp.rts || bus.grant !== m_exp.gnt ||
                        bus.xbar_sel !== m_exp.xs || bus.busy !== m_exp.busy) begin
                        n_err++;
                        $display("FAIL vec%0d t=%0t: got rts=%b grant=%b xbar_sel=%b busy=%b, want rts=%b grant=%b xbar_sel=%b busy=%b",
                                 n_vec, $time, bus.rts, bus.grant, bus.xbar_sel, bus.busy,
                                 m_exp.rts, m_exp.gnt, m_exp.xs, m_exp.busy);
                    end
                end
            end
        join_none

        // Reset held with dcts high, then quiet idle.
        step(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
        end

`ifdef ARB_PACKET_LOCK_EN
        // Packet lock: port 1 holds the link until its tail flit.
        step(1'b0, 5'b00010, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
        step(1'b0, 5'b01000, 5'b00000, 1'b1, 1'b1, 5'b00010, 5'b00010, 1'b1);
        step(1'b0, 5'b01000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b01000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b01010, 5'b11111, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b01010, 5'b11111, 1'b1, 1'b1, 5'b00010, 5'b00010, 1'b1);
        step(1'b0, 5'b01010, 5'b11111, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 5'b11111, 1'b1, 1'b1, 5'b01000, 5'b01000, 1'b1);
        step(1'b0, 5'b00000, 5'b11111, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
`else
        // First grant from ptr=0, then GAP re-serves port 2.
        step(1'b0, 5'b10100, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
        step(1'b0, 5'b10100, 5'b00000, 1'b1, 1'b1, 5'b00100, 5'b00100, 1'b1);
        step(1'b0, 5'b10100, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        // Stalled SEND holds while req toggles.
        step(1'b0, 5'b10100, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b1);
        step(1'b0, 5'b11111, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b1);
        step(1'b0, 5'b00011, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b1);
        step(1'b0, 5'b10000, 5'b00000, 1'b1, 1'b1, 5'b00100, 5'b00100, 1'b1);
        // GAP search from 2 finds 4, then wraps to 0.
        step(1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b10000, 5'b00000, 1'b1, 1'b1, 5'b10000, 5'b10000, 1'b1);
        step(1'b0, 5'b00001, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00001, 5'b00001, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        // IDLE search from ptr=1 picks port 1 over port 0.
        step(1'b0, 5'b00011, 5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0);
        step(1'b0, 5'b00011, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00010, 1'b1);
        step(1'b0, 5'b00011, 5'b00000, 1'b1, 1'b1, 5'b00010, 5'b00010, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        // IDLE search from ptr=2 wraps to port 0.
        step(1'b0, 5'b00011, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
        // Reset sampled during SEND with dcts high.
        step(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00001, 5'b00001, 1'b1);
        step(1'b0, 5'b11111, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
        // ptr restarted at 0, so port 0 wins over all others.
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00001, 5'b00001, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0);
`endif

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
